control_unit: RTL and testbench

- Multi-cycle instruction sequencer that drives the accumulator/ALU operation block.
- Fetches 16-bit instructions from a synchronous program ROM and decodes them.
- Generates operation_code, in_b and the accumulator enable for the operation block.
- Samples the operation block's Carry_flag for conditional jumps.

---
 rtl/control_unit.sv | 134 +++++++++++++
 tb/tb_control_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE sequencer that drives the accumulator/ALU operation block.
// Optional build macro CU_ILLEGAL_TRAP_EN: undefined classes trap into HALT instead of acting as NOP.
module control_unit #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [15:0]           rom_data,
   output logic [2:0]            operation_code,
   output logic [DATA_WIDTH-1:0] in_b,
   output logic                  aku_enable,
   input  logic                  Carry_flag,
   output logic                  carry,
   output logic                  halted,
   output logic                  illegal
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_HALT
   } state_t;

   typedef enum logic [3:0] {
      CL_NOP  = 4'd0,
      CL_ALUI = 4'd1,
      CL_JMP  = 4'd2,
      CL_JC   = 4'd3,
      CL_JNC  = 4'd4,
      CL_HALT = 4'd5
   } iclass_t;

   state_t                state;
   state_t                state_nxt;
   logic [15:0]           ir;
   logic [3:0]            ir_class;
   logic                  is_undef;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [ADDR_WIDTH-1:0] pc_nxt;
   logic [ADDR_WIDTH-1:0] jump_target;
   logic                  unused_ir11;

   assign ir_class    = ir[15:12];
   assign is_undef    = (ir_class > 4'd5);
   assign pc_inc      = pc + ADDR_WIDTH'(1);
   // Size cast zero-extends or truncates the 8-bit immediate to the pc width.
   assign jump_target = ADDR_WIDTH'(ir[7:0]);
   assign unused_ir11 = ir[11];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (run) state_nxt = S_FETCH;
         S_FETCH:   state_nxt = S_DECODE;
         S_DECODE:  state_nxt = S_EXECUTE;
         S_EXECUTE: begin
            state_nxt = S_FETCH;
            if (ir_class == CL_HALT) state_nxt = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
            if (is_undef) state_nxt = S_HALT;
`endif
         end
         S_HALT:    state_nxt = S_HALT;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      rom_addr       = pc;
      operation_code = ir[10:8];
      in_b           = DATA_WIDTH'(ir);
      aku_enable     = (state == S_EXECUTE) && (ir_class == CL_ALUI);
   end

   always_comb begin
      pc_nxt = pc_inc;
      case (ir_class)
         CL_JMP:  pc_nxt = jump_target;
         CL_JC:   pc_nxt = carry ? jump_target : pc_inc;
         CL_JNC:  pc_nxt = carry ? pc_inc : jump_target;
         default: pc_nxt = pc_inc;
      endcase
`ifdef CU_ILLEGAL_TRAP_EN
      if (is_undef) pc_nxt = pc;
`endif
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc     <= '0;
         ir     <= '0;
         carry  <= 1'b0;
         halted <= 1'b0;
      end else begin
         case (state)
            S_DECODE: ir <= rom_data;
            S_EXECUTE: begin
               pc <= pc_nxt;
               if (ir_class == CL_ALUI) carry  <= Carry_flag;
               if (ir_class == CL_HALT) halted <= 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
               if (is_undef) halted <= 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

`ifdef CU_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    illegal <= 1'b0;
      else if ((state == S_EXECUTE) && is_undef)  illegal <= 1'b1;
   end
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: ROM model, carry model and hand-computed expectations.
// Expectations for undefined classes follow the CU_ILLEGAL_TRAP_EN build macro.
module tb_control_unit;

   logic        clk;
   logic        rst;
   logic        run;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic [2:0]  operation_code;
   logic [7:0]  in_b;
   logic        aku_enable;
   logic        Carry_flag;
   logic        carry;
   logic        halted;
   logic        illegal;

   logic [15:0] rom [256];
   int unsigned checks = 0;
   int unsigned errors = 0;

   control_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .run            (run),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .operation_code (operation_code),
      .in_b           (in_b),
      .aku_enable     (aku_enable),
      .Carry_flag     (Carry_flag),
      .carry          (carry),
      .halted         (halted),
      .illegal        (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full instruction: FETCH -> DECODE -> EXECUTE -> next FETCH
   task automatic step();
      repeat (3) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic fill_rom();
      for (int unsigned i = 0; i < 256; i++) rom[i] = 16'h5000;
   endtask

   task automatic start();
      run = 1'b1;
      tick();
      run = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      run        = 1'b0;
      Carry_flag = 1'b0;
      fill_rom();
      rom[0] = 16'h160A;
      do_reset();

      // Reset asserted in the middle of a FETCH cycle
      run = 1'b1;
      tick();
      #2 rst = 1'b1;
      #1;
      chk("rst_rom_addr", 32'(rom_addr), 32'h0);
      chk("rst_opcode",   32'(operation_code), 32'h0);
      chk("rst_in_b",     32'(in_b), 32'h0);
      chk("rst_aku",      32'(aku_enable), 32'h0);
      chk("rst_carry",    32'(carry), 32'h0);
      chk("rst_halted",   32'(halted), 32'h0);
      chk("rst_illegal",  32'(illegal), 32'h0);
      tick();
      run = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_rom_addr", 32'(rom_addr), 32'h0);
         chk("idle_aku",      32'(aku_enable), 32'h0);
      end

      // ALUI timing: strobe only in the third cycle after run
      start();
      chk("alui_c1_aku", 32'(aku_enable), 32'h0);
      tick();
      chk("alui_c2_aku", 32'(aku_enable), 32'h0);
      tick();
      chk("alui_c3_aku",    32'(aku_enable), 32'h1);
      chk("alui_c3_opcode", 32'(operation_code), 32'h6);
      chk("alui_c3_in_b",   32'(in_b), 32'h0A);
      chk("alui_c3_pc",     32'(rom_addr), 32'h0);
      tick();
      chk("alui_c4_aku",    32'(aku_enable), 32'h0);
      chk("alui_pc_after",  32'(rom_addr), 32'h1);
      chk("alui_opcode_hold", 32'(operation_code), 32'h6);

      // Reset during EXECUTE drops the pending strobe
      do_reset();
      start();
      tick();
      tick();
      chk("exec_aku_before_rst", 32'(aku_enable), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("exec_aku_after_rst", 32'(aku_enable), 32'h0);
      chk("exec_pc_after_rst",  32'(rom_addr), 32'h0);

      // Carry set, JC taken, JNC not taken; IR[11] ignored
      fill_rom();
      rom[0]    = 16'h19FF;
      rom[1]    = 16'h3020;
      rom[8'h20] = 16'h4050;
      do_reset();
      Carry_flag = 1'b1;
      start();
      tick();
      tick();
      chk("alui_bit11_opcode", 32'(operation_code), 32'h1);
      chk("alui_bit11_in_b",   32'(in_b), 32'hFF);
      tick();
      Carry_flag = 1'b0;
      chk("carry_set",     32'(carry), 32'h1);
      chk("carry_pc",      32'(rom_addr), 32'h1);
      step();
      chk("jc_taken_pc",   32'(rom_addr), 32'h20);
      chk("jc_keep_carry", 32'(carry), 32'h1);
      step();
      chk("jnc_not_taken_pc", 32'(rom_addr), 32'h21);
      step();
      chk("halt_at_21",    32'(halted), 32'h1);

      // Carry clear: JC not taken, JNC taken, JMP to top, NOP wraps pc
      fill_rom();
      rom[0]     = 16'h1203;
      rom[1]     = 16'h3020;
      rom[2]     = 16'h4040;
      rom[8'h40] = 16'h20FF;
      rom[8'hFF] = 16'h0000;
      do_reset();
      Carry_flag = 1'b0;
      start();
      step();
      chk("carry_clear",     32'(carry), 32'h0);
      step();
      chk("jc_not_taken_pc", 32'(rom_addr), 32'h2);
      step();
      chk("jnc_taken_pc",    32'(rom_addr), 32'h40);
      step();
      chk("jmp_pc",          32'(rom_addr), 32'hFF);
      step();
      chk("nop_wrap_pc",     32'(rom_addr), 32'h0);
      chk("wrap_not_halted", 32'(halted), 32'h0);

      // HALT at address 3; run ignored afterwards; reset clears it
      fill_rom();
      rom[0] = 16'h0000;
      rom[1] = 16'h0000;
      rom[2] = 16'h0000;
      rom[3] = 16'h5000;
      do_reset();
      start();
      step();
      step();
      step();
      chk("halt_fetch_addr", 32'(rom_addr), 32'h3);
      chk("halt_pre",        32'(halted), 32'h0);
      tick();
      tick();
      chk("halt_exec",       32'(halted), 32'h0);
      tick();
      chk("halt_set",        32'(halted), 32'h1);
      chk("halt_pc",         32'(rom_addr), 32'h4);
      for (int i = 0; i < 6; i++) begin
         run = (i % 2 == 0);
         tick();
         chk("halt_run_pc",  32'(rom_addr), 32'h4);
         chk("halt_run_aku", 32'(aku_enable), 32'h0);
      end
      run = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("halt_cleared",    32'(halted), 32'h0);
      chk("halt_rst_pc",     32'(rom_addr), 32'h0);
      tick();
      rst = 1'b0;

      // Undefined class 0xF at address 0
      fill_rom();
      rom[0] = 16'hF000;
      rom[1] = 16'h5000;
      do_reset();
      start();
      step();
`ifdef CU_ILLEGAL_TRAP_EN
      chk("trap_illegal", 32'(illegal), 32'h1);
      chk("trap_halted",  32'(halted), 32'h1);
      chk("trap_pc",      32'(rom_addr), 32'h0);
      run = 1'b1;
      step();
      run = 1'b0;
      chk("trap_stuck_pc", 32'(rom_addr), 32'h0);
`else
      chk("undef_illegal", 32'(illegal), 32'h0);
      chk("undef_halted",  32'(halted), 32'h0);
      chk("undef_pc",      32'(rom_addr), 32'h1);
      step();
      chk("undef_continue_halt", 32'(halted), 32'h1);
      chk("undef_continue_pc",   32'(rom_addr), 32'h2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
